dbus_xbar_1ton: RTL and testbench

Parametrised 1-to-N data-bus demultiplexer between the CPU data-memory port (req/gnt/rvalid protocol) and N peripheral slaves (RAM, IO module, UART0, Timer, Timer1, ...). It decodes each request against a per-slave base/size table and forwards it with a slave-local address. It tracks up to MAX_OUTST outstanding transactions and returns responses in order. Unmapped accesses are answered internally with err=1. It replaces fixed per-peripheral address compare and supports pipelined (multiple in-flight) accesses.

---
 rtl/dbus_map_pkg.sv | 26 ++
 rtl/dbus_resp_fifo.sv | 59 +++++
 rtl/dbus_xbar_1ton.sv | 146 ++++++++++++++
 tb/tb_dbus_xbar_1ton.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_map_pkg.sv
// rtl/dbus_map_pkg.sv - data-bus address map and response-tracking types
package dbus_map_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_3000;
  localparam logic [31:0] RAM_SIZE    = 32'h0000_1000;
  localparam logic [31:0] IO_BASE     = 32'h0000_4000;
  localparam logic [31:0] IO_SIZE     = 32'h0000_000C;
  localparam logic [31:0] UART0_BASE  = 32'h0000_400C;
  localparam logic [31:0] UART0_SIZE  = 32'h0000_0014;
  localparam logic [31:0] TIMER_BASE  = 32'h0000_4020;
  localparam logic [31:0] TIMER_SIZE  = 32'h0000_0060;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_4080;
  localparam logic [31:0] TIMER1_SIZE = 32'h0000_0060;

  // Slave 0 occupies the least significant word
  localparam logic [5*32-1:0] DEF_SLV_BASE =
    {TIMER1_BASE, TIMER_BASE, UART0_BASE, IO_BASE, RAM_BASE};
  localparam logic [5*32-1:0] DEF_SLV_SIZE =
    {TIMER1_SIZE, TIMER_SIZE, UART0_SIZE, IO_SIZE, RAM_SIZE};

  typedef struct packed {
    logic       decerr;
    logic [2:0] idx;
  } resp_ent_t;

endpackage

// File: rtl/dbus_resp_fifo.sv
// rtl/dbus_resp_fifo.sv - in-order response tracking FIFO
module dbus_resp_fifo
  import dbus_map_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  resp_ent_t     ent_i,
  input  logic          pop_i,
  output resp_ent_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  resp_ent_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO may push when it pops: the write lands in the slot being freed
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= ent_i;
    end
  end

endmodule

// File: rtl/dbus_xbar_1ton.sv
// rtl/dbus_xbar_1ton.sv - 1-to-N data-bus demux with in-order pipelined responses
module dbus_xbar_1ton
  import dbus_map_pkg::*;
#(
  parameter  int                   N_SLV     = 5,
  parameter  int                   AW        = 32,
  parameter  int                   DW        = 32,
  parameter  int                   SW        = 4,
  parameter  int                   MAX_OUTST = 2,
  parameter  logic [N_SLV*AW-1:0]  SLV_BASE  = DEF_SLV_BASE,
  parameter  logic [N_SLV*AW-1:0]  SLV_SIZE  = DEF_SLV_SIZE,
  localparam int                   CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_req_i,
  input  logic                m_we_i,
  input  logic [SW-1:0]       m_be_i,
  input  logic [AW-1:0]       m_addr_i,
  input  logic [DW-1:0]       m_wdata_i,
  output logic                m_gnt_o,
  output logic                m_rvalid_o,
  output logic [DW-1:0]       m_rdata_o,
  output logic                m_err_o,
  output logic [N_SLV-1:0]    s_req_o,
  output logic                s_we_o,
  output logic [SW-1:0]       s_be_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic [N_SLV-1:0]    s_gnt_i,
  input  logic [N_SLV-1:0]    s_rvalid_i,
  input  logic [N_SLV*DW-1:0] s_rdata_i,
  input  logic [N_SLV-1:0]    s_err_i,
  output logic [CW-1:0]       outst_o,
  output logic                proto_err_o
);

  logic          hit;
  logic [2:0]    sel_idx;
  logic [AW-1:0] local_addr;
  logic [AW-1:0] base_v, off_v;
  logic          sel_gnt;
  logic          can_push, fwd, pop;
  logic          full, empty;
  resp_ent_t     head, push_ent;
  logic          head_rvalid, head_err;
  logic [DW-1:0] head_rdata;
  logic [N_SLV-1:0] expect_mask;
  logic          proto_err_q, proto_err_d;

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit        = 1'b0;
    sel_idx    = '0;
    local_addr = '0;
    base_v     = '0;
    off_v      = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      base_v = SLV_BASE[i*AW +: AW];
      off_v  = m_addr_i - base_v;
      if ((m_addr_i >= base_v) && (off_v < SLV_SIZE[i*AW +: AW])) begin
        hit        = 1'b1;
        sel_idx    = 3'(i);
        local_addr = off_v;
      end
    end
  end

  always_comb begin
    sel_gnt = 1'b0;
    for (int i = 0; i < N_SLV; i++)
      if (sel_idx == 3'(i)) sel_gnt = s_gnt_i[i];
  end

  assign can_push = !full || pop;
  assign fwd      = m_req_i && can_push && hit;
  assign m_gnt_o  = m_req_i && can_push && (hit ? sel_gnt : 1'b1);

  always_comb begin
    for (int i = 0; i < N_SLV; i++) s_req_o[i] = fwd && (sel_idx == 3'(i));
  end

  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_addr_o  = local_addr;
  assign s_wdata_o = m_wdata_i;

  assign push_ent.decerr = !hit;
  assign push_ent.idx    = hit ? sel_idx : 3'd0;

  dbus_resp_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (m_gnt_o),
    .ent_i   (push_ent),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (outst_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    head_err    = 1'b0;
    expect_mask = '0;
    for (int j = 0; j < N_SLV; j++) begin
      if (head.idx == 3'(j)) begin
        head_rvalid = s_rvalid_i[j];
        head_rdata  = s_rdata_i[j*DW +: DW];
        head_err    = s_err_i[j];
        expect_mask[j] = !empty && !head.decerr;
      end
    end
  end

  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    pop        = 1'b0;
    if (!empty) begin
      if (head.decerr) begin
        m_rvalid_o = 1'b1;
        m_err_o    = 1'b1;
        pop        = 1'b1;
      end else begin
        m_rvalid_o = head_rvalid;
        m_rdata_o  = head_rdata;
        m_err_o    = head_err;
        pop        = head_rvalid;
      end
    end
  end

  // Any response not from the slave owning the head entry is out of order
  assign proto_err_d = proto_err_q || (|(s_rvalid_i & ~expect_mask));
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
  end

endmodule

// File: tb/tb_dbus_xbar_1ton.sv
// tb/tb_dbus_xbar_1ton.sv - directed self-checking bench for dbus_xbar_1ton
module tb_dbus_xbar_1ton;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req, m_we;
  logic [3:0]   m_be;
  logic [31:0]  m_addr, m_wdata;
  logic         m_gnt, m_rvalid, m_err;
  logic [31:0]  m_rdata;
  logic [4:0]   s_req;
  logic         s_we;
  logic [3:0]   s_be;
  logic [31:0]  s_addr, s_wdata;
  logic [4:0]   s_gnt, s_rvalid, s_err;
  logic [159:0] s_rdata;
  logic [1:0]   outst;
  logic         proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dbus_xbar_1ton dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_gnt_o     (m_gnt),
    .m_rvalid_o  (m_rvalid),
    .m_rdata_o   (m_rdata),
    .m_err_o     (m_err),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_be_o      (s_be),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_gnt_i     (s_gnt),
    .s_rvalid_i  (s_rvalid),
    .s_rdata_i   (s_rdata),
    .s_err_i     (s_err),
    .outst_o     (outst),
    .proto_err_o (proto_err)
  );

  // Advance to just after the next rising edge; checks happen 4 time units later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = 0; m_we = 0; m_be = 4'hF; m_addr = 0; m_wdata = 0;
    s_gnt = 0; s_rvalid = 0; s_err = 0; s_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); #4;
    n_cmp++; if (outst !== 2'd0) begin n_fail++; $display("FAIL reset_outst got %0d want 0", outst); end
    n_cmp++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", m_rvalid); end
    n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto got %b want 0", proto_err); end
    n_cmp++; if (s_req !== 5'b0) begin n_fail++; $display("FAIL reset_sreq got %b want 00000", s_req); end
    cyc();
    rst = 0;
  endtask

  task automatic test_ram_read();
    cyc();
    m_req = 1; m_we = 0; m_addr = 32'h3004; s_gnt = 5'b00001; #4;
    n_cmp++; if (s_req !== 5'b00001) begin n_fail++; $display("FAIL ram_sreq got %b want 00001", s_req); end
    n_cmp++; if (s_addr !== 32'h4) begin n_fail++; $display("FAIL ram_saddr got %h want 4", s_addr); end
    n_cmp++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL ram_gnt got %b want 1", m_gnt); end
    n_cmp++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL ram_early_rvalid got %b want 0", m_rvalid); end
    cyc();
    m_req = 0; s_gnt = 0; s_rvalid = 5'b00001; s_rdata[31:0] = 32'hDEADBEEF; #4;
    n_cmp++; if (outst !== 2'd1) begin n_fail++; $display("FAIL ram_outst got %0d want 1", outst); end
    n_cmp++; if (m_rvalid !== 1'b1) begin n_fail++; $display("FAIL ram_rvalid got %b want 1", m_rvalid); end
    n_cmp++; if (m_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rdata got %h want deadbeef", m_rdata); end
    n_cmp++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL ram_err got %b want 0", m_err); end
    cyc();
    s_rvalid = 0; #4;
    n_cmp++; if (outst !== 2'd0) begin n_fail++; $display("FAIL ram_drain got %0d want 0", outst); end
  endtask

  task automatic test_uart_write();
    cyc();
    m_req = 1; m_we = 1; m_addr = 32'h4010; m_wdata = 32'hA5A5_0001; m_be = 4'h3; s_gnt = 5'b00100; #4;
    n_cmp++; if (s_req !== 5'b00100) begin n_fail++; $display("FAIL uart_sreq got %b want 00100", s_req); end
    n_cmp++; if (s_addr !== 32'h4) begin n_fail++; $display("FAIL uart_saddr got %h want 4", s_addr); end
    n_cmp++; if ({s_we, s_be, s_wdata} !== {1'b1, 4'h3, 32'hA5A5_0001}) begin n_fail++; $display("FAIL uart_bcast got %b/%h/%h want 1/3/a5a50001", s_we, s_be, s_wdata); end
    cyc();
    m_req = 0; m_we = 0; m_be = 4'hF; s_gnt = 0; s_rvalid = 5'b00100; #4;
    n_cmp++; if ({m_rvalid, m_err} !== 2'b10) begin n_fail++; $display("FAIL uart_resp got %b%b want 10", m_rvalid, m_err); end
    cyc();
    s_rvalid = 0;
  endtask

  task automatic test_decerr();
    cyc();
    m_req = 1; m_addr = 32'h5000; s_gnt = 5'b0; #4;
    n_cmp++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL decerr_gnt got %b want 1", m_gnt); end
    n_cmp++; if (s_req !== 5'b0) begin n_fail++; $display("FAIL decerr_sreq got %b want 00000", s_req); end
    cyc();
    m_req = 0; #4;
    n_cmp++; if ({m_rvalid, m_err} !== 2'b11) begin n_fail++; $display("FAIL decerr_resp got %b%b want 11", m_rvalid, m_err); end
    n_cmp++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL decerr_rdata got %h want 0", m_rdata); end
    cyc(); #4;
    n_cmp++; if (outst !== 2'd0) begin n_fail++; $display("FAIL decerr_drain got %0d want 0", outst); end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [5];
    logic [4:0]  reqs  [5];
    logic [31:0] locs  [5];
    addrs = '{32'h3FFF, 32'h400B, 32'h400C, 32'h407F, 32'h40DF};
    reqs  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    locs  = '{32'hFFF,  32'hB,    32'h0,    32'h5F,   32'h5F};
    for (int k = 0; k < 5; k++) begin
      cyc();
      m_req = 1; m_addr = addrs[k]; s_gnt = 0; #4;
      n_cmp++; if ({s_req, s_addr} !== {reqs[k], locs[k]}) begin n_fail++; $display("FAIL bound_%h got %b/%h want %b/%h", addrs[k], s_req, s_addr, reqs[k], locs[k]); end
    end
    cyc();
    m_addr = 32'h2FFF; #4;
    n_cmp++; if ({m_gnt, s_req} !== {1'b1, 5'b0}) begin n_fail++; $display("FAIL bound_below_ram got %b/%b want 1/00000", m_gnt, s_req); end
    cyc();
    m_addr = 32'h40E0; #4;
    n_cmp++; if ({m_gnt, s_req, m_rvalid} !== {1'b1, 5'b0, 1'b1}) begin n_fail++; $display("FAIL bound_above_t1 got %b/%b/%b want 1/00000/1", m_gnt, s_req, m_rvalid); end
    cyc();
    m_req = 0; cyc(); cyc(); #4;
    n_cmp++; if (outst !== 2'd0) begin n_fail++; $display("FAIL bound_drain got %0d want 0", outst); end
  endtask

  task automatic test_back_to_back();
    cyc();
    m_req = 1; m_addr = 32'h3000; s_gnt = 5'b11111; #4;
    n_cmp++; if ({m_gnt, s_req} !== {1'b1, 5'b00001}) begin n_fail++; $display("FAIL b2b_ram_issue got %b/%b want 1/00001", m_gnt, s_req); end
    cyc();
    m_addr = 32'h4020; #4;
    n_cmp++; if ({m_gnt, s_req} !== {1'b1, 5'b01000}) begin n_fail++; $display("FAIL b2b_tmr_issue got %b/%b want 1/01000", m_gnt, s_req); end
    cyc();
    m_addr = 32'h3008; s_rvalid = 5'b01000; s_rdata[127:96] = 32'hBAD0_BAD0; #4;
    n_cmp++; if ({m_gnt, s_req, outst} !== {1'b0, 5'b0, 2'd2}) begin n_fail++; $display("FAIL b2b_stall got %b/%b/%0d want 0/00000/2", m_gnt, s_req, outst); end
    n_cmp++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_tmr got %b want 0", m_rvalid); end
    cyc();
    s_rvalid = 0; #4;
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL b2b_proto got %b want 1", proto_err); end
    cyc();
    s_rvalid = 5'b00001; s_rdata[31:0] = 32'h1111_1111; #4;
    n_cmp++; if ({m_gnt, m_rvalid, m_rdata} !== {1'b1, 1'b1, 32'h1111_1111}) begin n_fail++; $display("FAIL full_pop_push got %b/%b/%h want 1/1/11111111", m_gnt, m_rvalid, m_rdata); end
    cyc();
    m_req = 0; s_rvalid = 5'b01000; s_rdata[127:96] = 32'h2222_2222; #4;
    n_cmp++; if (outst !== 2'd2) begin n_fail++; $display("FAIL full_outst got %0d want 2", outst); end
    n_cmp++; if ({m_rvalid, m_rdata} !== {1'b1, 32'h2222_2222}) begin n_fail++; $display("FAIL b2b_tmr_resp got %b/%h want 1/22222222", m_rvalid, m_rdata); end
    cyc();
    s_rvalid = 5'b00001; s_rdata[31:0] = 32'h3333_3333; #4;
    n_cmp++; if ({outst, m_rvalid, m_rdata} !== {2'd1, 1'b1, 32'h3333_3333}) begin n_fail++; $display("FAIL b2b_ram2_resp got %0d/%b/%h want 1/1/33333333", outst, m_rvalid, m_rdata); end
    cyc();
    s_rvalid = 0; s_gnt = 0; #4;
    n_cmp++; if ({outst, proto_err} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL b2b_end got %0d/%b want 0/1", outst, proto_err); end
  endtask

  task automatic test_reset_midflight();
    cyc();
    m_req = 1; m_addr = 32'h3000; s_gnt = 5'b11111;
    cyc();
    m_addr = 32'h4020;
    cyc();
    m_req = 0; s_gnt = 0; #4;
    n_cmp++; if (outst !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre got %0d want 2", outst); end
    cyc();
    rst = 1;
    cyc();
    rst = 0; #4;
    n_cmp++; if ({outst, m_rvalid, m_err, m_rdata, m_gnt, s_req, proto_err} !== '0) begin n_fail++; $display("FAIL rstmid_clear got %0d/%b/%b/%h/%b/%b/%b want all 0", outst, m_rvalid, m_err, m_rdata, m_gnt, s_req, proto_err); end
    cyc();
    s_rvalid = 5'b00001; s_rdata[31:0] = 32'h5555_5555; #4;
    n_cmp++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_rvalid got %b want 0", m_rvalid); end
    cyc();
    s_rvalid = 0; #4;
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_stale_proto got %b want 1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_uart_write();
    test_decerr();
    test_boundary();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
